// File: rtl/ahb_rr_arbiter_if.sv
// rtl/ahb_rr_arbiter_if.sv - request/transfer inputs and grant outputs of the round-robin AHB arbiter
interface ahb_rr_arbiter_if #(
    parameter int NUM_MGR = 4
) ();
    logic [NUM_MGR-1:0] req;
    logic [1:0]         HTRANS;
    logic [2:0]         HBURST;
    logic               HMASTLOCK;
    logic               HREADY;
    logic [NUM_MGR-1:0] grant;
    logic               grant_valid;
    logic               handover;

    // Interconnect side: drives requests and the post-mux transfer controls
    modport master (
        output req, HTRANS, HBURST, HMASTLOCK, HREADY,
        input  grant, grant_valid, handover
    );

    // Arbiter side
    modport slave (
        input  req, HTRANS, HBURST, HMASTLOCK, HREADY,
        output grant, grant_valid, handover
    );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// rtl/ahb_rr_arbiter.sv - round-robin AHB arbiter honouring bursts, BUSY and lock; ARB_PARK_LAST_EN parks on last owner
module ahb_rr_arbiter #(
    parameter int NUM_MGR = 4
) (
    input  logic             clk,
    input  logic             reset,
    ahb_rr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {ARB, BURST, UNDEF, LOCK} state_t;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [NUM_MGR-1:0] ONE = NUM_MGR'(1);

    state_t             state, state_nxt;
    logic [3:0]         beats_left, beats_nxt;
    logic [NUM_MGR-1:0] grant, grant_nxt;
    logic               handover, handover_nxt;
    logic [NUM_MGR-1:0] req_hi, arb_pick, park;
    logic               do_arb, owner_req;

`ifdef ARB_PARK_LAST_EN
    assign park = grant;
`else
    assign park = ONE;
`endif

    assign owner_req = |(bus.req & grant);

    // Round-robin pick: lowest requester above the owner, else lowest overall (owner last)
    always_comb begin
        req_hi = bus.req & ~(grant | (grant - ONE));
        if (req_hi != '0)
            arb_pick = req_hi & (~req_hi + ONE);
        else if (bus.req != '0)
            arb_pick = bus.req & (~bus.req + ONE);
        else
            arb_pick = park;
    end

    // Next state: only accepted beats move the FSM; lock overrides any arbitration point
    always_comb begin
        state_nxt = state;
        beats_nxt = beats_left;
        do_arb    = 1'b0;
        if (bus.HREADY) begin
            if (bus.HMASTLOCK) begin
                state_nxt = LOCK;
            end else begin
                case (state)
                    ARB: begin
                        if (bus.HTRANS == T_IDLE) begin
                            do_arb = 1'b1;
                        end else if (bus.HTRANS == T_NONSEQ) begin
                            case (bus.HBURST)
                                3'b000: do_arb = 1'b1;
                                3'b001: state_nxt = UNDEF;
                                3'b010, 3'b011: begin beats_nxt = 4'd3;  state_nxt = BURST; end
                                3'b100, 3'b101: begin beats_nxt = 4'd7;  state_nxt = BURST; end
                                default:        begin beats_nxt = 4'd15; state_nxt = BURST; end
                            endcase
                        end
                    end
                    BURST: begin
                        if (bus.HTRANS == T_SEQ) begin
                            if (beats_left == 4'd1)
                                do_arb = 1'b1;
                            else
                                beats_nxt = beats_left - 4'd1;
                        end else if (bus.HTRANS == T_IDLE) begin
                            do_arb = 1'b1;
                        end
                    end
                    UNDEF: begin
                        if (!owner_req || bus.HTRANS == T_IDLE)
                            do_arb = 1'b1;
                    end
                    default: begin
                        if (bus.HTRANS == T_IDLE)
                            do_arb = 1'b1;
                    end
                endcase
            end
            if (do_arb) begin
                state_nxt = ARB;
                beats_nxt = '0;
            end
        end
        grant_nxt    = do_arb ? arb_pick : grant;
        handover_nxt = do_arb && (arb_pick != grant);
    end

    // State, burst counter and registered grant/handover
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB;
            beats_left <= '0;
            grant      <= ONE;
            handover   <= 1'b0;
        end else begin
            state      <= state_nxt;
            beats_left <= beats_nxt;
            grant      <= grant_nxt;
            handover   <= handover_nxt;
        end
    end

    assign bus.grant       = grant;
    assign bus.handover    = handover;
    assign bus.grant_valid = |(grant & bus.req);
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb/tb_ahb_rr_arbiter.sv - directed self-checking bench for ahb_rr_arbiter with a behavioural model
module tb_ahb_rr_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ahb_rr_arbiter_if #(.NUM_MGR(N)) bus ();

    ahb_rr_arbiter #(.NUM_MGR(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: owner index, activity mode (0 free, 1 fixed burst, 2 open burst, 3 locked)
    int m_owner;
    int m_mode;
    int m_remaining;
    bit m_hand;

    function automatic int rr_pick(input int own, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(own + k) % N]) return (own + k) % N;
        end
`ifdef ARB_PARK_LAST_EN
        return own;
`else
        return 0;
`endif
    endfunction

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'b010, 3'b011: return 4;
            3'b100, 3'b101: return 8;
            default:        return 16;
        endcase
    endfunction

    // Model update on every clock edge, cleared by reset
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = 0; m_mode = 0; m_remaining = 0; m_hand = 0;
        end else begin
            bit arb;
            int nxt;
            arb = 0;
            m_hand = 0;
            if (bus.HREADY) begin
                if (bus.HMASTLOCK) begin
                    m_mode = 3;
                end else if (m_mode == 3) begin
                    if (bus.HTRANS == 2'b00) arb = 1;
                end else if (m_mode == 0) begin
                    if (bus.HTRANS == 2'b00) arb = 1;
                    else if (bus.HTRANS == 2'b10) begin
                        if (bus.HBURST == 3'b000) arb = 1;
                        else if (bus.HBURST == 3'b001) m_mode = 2;
                        else begin m_mode = 1; m_remaining = burst_len(bus.HBURST) - 1; end
                    end
                end else if (m_mode == 1) begin
                    if (bus.HTRANS == 2'b11) begin
                        m_remaining = m_remaining - 1;
                        if (m_remaining == 0) arb = 1;
                    end else if (bus.HTRANS == 2'b00) arb = 1;
                end else begin
                    if (!bus.req[m_owner] || bus.HTRANS == 2'b00) arb = 1;
                end
                if (arb) begin
                    m_mode = 0;
                    m_remaining = 0;
                    nxt = rr_pick(m_owner, bus.req);
                    m_hand = (nxt != m_owner);
                    m_owner = nxt;
                end
            end
        end
    end

    // Per-cycle comparison against the model on the falling edge
    always @(negedge clk) begin
        logic [N-1:0] eg;
        eg = N'(1 << m_owner);
        checks++;
        if (bus.grant !== eg) begin
            errors++;
            $display("FAIL cmp_grant t=%0t actual=%b required=%b", $time, bus.grant, eg);
        end
        checks++;
        if (bus.handover !== m_hand) begin
            errors++;
            $display("FAIL cmp_handover t=%0t actual=%b required=%b", $time, bus.handover, m_hand);
        end
        checks++;
        if (bus.grant_valid !== |(eg & bus.req)) begin
            errors++;
            $display("FAIL cmp_grant_valid t=%0t actual=%b required=%b", $time, bus.grant_valid, |(eg & bus.req));
        end
    end

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [1:0] t, input logic [2:0] b,
                        input logic l, input logic rdy);
        bus.req = r; bus.HTRANS = t; bus.HBURST = b; bus.HMASTLOCK = l; bus.HREADY = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req = '0; bus.HTRANS = 2'b00; bus.HBURST = 3'b000; bus.HMASTLOCK = 1'b0; bus.HREADY = 1'b0;
        #12;
        chk("reset_grant", bus.grant, 4'b0001);
        chk("reset_handover", {3'b000, bus.handover}, 4'b0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: idle with no requests
        step(4'b0000, 2'b00, 3'b000, 1'b0, 1'b1);
        chk("t1_grant", bus.grant, 4'b0001);
        chk("t1_handover", {3'b000, bus.handover}, 4'b0000);
        chk("t1_grant_valid", {3'b000, bus.grant_valid}, 4'b0000);

        // 2: rotation with all requesting
        step(4'b1111, 2'b00, 3'b000, 1'b0, 1'b1);
        chk("t2_g1", bus.grant, 4'b0010);
        chk("t2_h1", {3'b000, bus.handover}, 4'b0001);
        step(4'b1111, 2'b00, 3'b000, 1'b0, 1'b1);
        chk("t2_g2", bus.grant, 4'b0100);
        step(4'b1111, 2'b00, 3'b000, 1'b0, 1'b1);
        chk("t2_g3", bus.grant, 4'b1000);
        step(4'b1111, 2'b00, 3'b000, 1'b0, 1'b1);
        chk("t2_g4", bus.grant, 4'b0001);
        chk("t2_h4", {3'b000, bus.handover}, 4'b0001);
        chk("t2_gv", {3'b000, bus.grant_valid}, 4'b0001);

        // 3: mgr1 INCR4 with BUSY and a wait state
        step(4'b0010, 2'b00, 3'b000, 1'b0, 1'b1);
        chk("t3_own", bus.grant, 4'b0010);
        step(4'b1111, 2'b10, 3'b011, 1'b0, 1'b1);
        chk("t3_nonseq", bus.grant, 4'b0010);
        step(4'b1111, 2'b11, 3'b011, 1'b0, 1'b1);
        step(4'b1111, 2'b01, 3'b011, 1'b0, 1'b1);
        step(4'b1111, 2'b11, 3'b011, 1'b0, 1'b0);
        step(4'b1111, 2'b11, 3'b011, 1'b0, 1'b1);
        chk("t3_before_last", bus.grant, 4'b0010);
        step(4'b1111, 2'b11, 3'b011, 1'b0, 1'b1);
        chk("t3_after_last", bus.grant, 4'b0100);
        chk("t3_handover", {3'b000, bus.handover}, 4'b0001);

        // 4: mgr2 locked
        step(4'b1011, 2'b00, 3'b000, 1'b1, 1'b1);
        step(4'b1011, 2'b00, 3'b000, 1'b1, 1'b1);
        chk("t4_locked", bus.grant, 4'b0100);
        step(4'b1011, 2'b10, 3'b000, 1'b0, 1'b1);
        chk("t4_unlock_nonidle", bus.grant, 4'b0100);
        step(4'b1011, 2'b00, 3'b000, 1'b0, 1'b1);
        chk("t4_release", bus.grant, 4'b1000);

        // 5: mgr3 undefined-length INCR
        step(4'b1000, 2'b10, 3'b001, 1'b0, 1'b1);
        step(4'b1000, 2'b11, 3'b001, 1'b0, 1'b1);
        step(4'b1001, 2'b11, 3'b001, 1'b0, 1'b1);
        step(4'b1001, 2'b01, 3'b001, 1'b0, 1'b1);
        step(4'b0001, 2'b11, 3'b001, 1'b0, 1'b0);
        chk("t5_hold", bus.grant, 4'b1000);
        step(4'b0001, 2'b11, 3'b001, 1'b0, 1'b1);
        chk("t5_end", bus.grant, 4'b0001);

        // 6: reset mid-INCR8 then parking
        step(4'b0100, 2'b00, 3'b000, 1'b0, 1'b1);
        step(4'b0100, 2'b10, 3'b101, 1'b0, 1'b1);
        step(4'b0100, 2'b11, 3'b101, 1'b0, 1'b1);
        step(4'b0100, 2'b11, 3'b101, 1'b0, 1'b1);
        chk("t6_in_burst", bus.grant, 4'b0100);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_reset", bus.grant, 4'b0001);
        @(posedge clk); #1;
        reset = 1'b0;
        step(4'b0100, 2'b10, 3'b000, 1'b0, 1'b1);
        chk("t6_single", bus.grant, 4'b0100);
        step(4'b0000, 2'b00, 3'b000, 1'b0, 1'b1);
`ifdef ARB_PARK_LAST_EN
        chk("t6_park", bus.grant, 4'b0100);
        chk("t6_park_handover", {3'b000, bus.handover}, 4'b0000);
`else
        chk("t6_park", bus.grant, 4'b0001);
        chk("t6_park_handover", {3'b000, bus.handover}, 4'b0001);
`endif
        step(4'b0000, 2'b00, 3'b000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_rr_arbiter.md
Name: ahb_rr_arbiter

Overview:
- Round-robin bus arbiter for the multi-manager AHB interconnect.
- Sits directly upstream of the one-hot-to-binary decoder. Produces the registered one-hot grant vector; the decoder turns it into the manager-select index for the address/data muxes.
- Honours AHB burst boundaries, BUSY beats and HMASTLOCK, so ownership changes only at legal handover points.

Parameters:
- NUM_MGR, 4, number of AHB managers; must be ≥2. The grant vector width equals NUM_MGR.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_MGR  per-manager bus request; bit i is manager i.
- HTRANS  input  2  transfer type of the currently granted manager (post-mux).
- HBURST  input  3  burst type of the currently granted manager (post-mux).
- HMASTLOCK  input  1  lock of the currently granted manager (post-mux).
- HREADY  input  1  bus-wide ready; 1 means the address phase is accepted this cycle.
- grant  output  NUM_MGR  registered one-hot grant; exactly one bit set at all times.
- grant_valid  output  1  combinational `|(grant & req)`.
- handover  output  1  registered; 1-cycle pulse in the cycle after grant changed owner.

Behaviour:
- Reset (async assert, sync release):
  - grant = 1 (manager 0); handover = 0.
  - beats_left = 0; state = ARB.
- "Accepted beat" means HREADY=1 at a rising edge. No state or grant change occurs on any edge with HREADY=0.
- States:
  - ARB: arbitration allowed on each HREADY=1 edge, unless HMASTLOCK=1 or HTRANS=BUSY(01).
  - BURST: fixed-length burst in progress.
  - UNDEF: INCR (HBURST=001) undefined-length burst in progress.
  - LOCK: HMASTLOCK held.
- Transitions on an accepted beat:
  - ARB, HTRANS=NONSEQ(10):
    - HBURST=SINGLE(000): arbitrate this edge.
    - HBURST=INCR4/WRAP4: load beats_left=3 and go to BURST.
    - HBURST=INCR8/WRAP8: load beats_left=7 and go to BURST.
    - HBURST=INCR16/WRAP16: load beats_left=15 and go to BURST.
    - HBURST=INCR: go to UNDEF.
  - ARB, HTRANS=IDLE(00): arbitrate.
  - BURST, HTRANS=SEQ(11): decrement beats_left. When beats_left is 1 at this edge, arbitrate and return to ARB.
  - BURST, HTRANS=BUSY: hold, no decrement.
  - BURST, HTRANS=IDLE: early termination; clear beats_left, arbitrate, return to ARB.
  - UNDEF: stay while the owner's req=1 and HTRANS is SEQ or BUSY. Arbitrate and return to ARB when the owner's req=0 or HTRANS=IDLE.
  - LOCK: entered from any state when HMASTLOCK=1 on an accepted beat. No arbitration while locked. Exit to ARB, with arbitration on that same edge, at the first accepted beat with HMASTLOCK=0 and HTRANS=IDLE.
- Arbitration:
  - Search req starting at index (owner+1) mod NUM_MGR, wrapping around; the first set bit wins.
  - The current owner is eligible last, so it wins only when it is the sole requester.
  - If req=0, park per Optional Feature.
  - New grant is visible the cycle after the arbitration edge.
  - handover=1 that cycle only if the new grant differs from the old one.
- Simultaneous events:
  - HMASTLOCK=1 takes priority over any arbitration point on the same edge.
  - req changes mid-burst have no effect until the next arbitration point.
- Invariants:
  - grant is never 0 and never multi-hot, in every state including reset.
  - Reset mid-burst or mid-lock immediately forces grant=1 and state ARB.

Optional Feature:
- Macro: ARB_PARK_LAST_EN.
- Defined: when an arbitration point finds req=0, grant stays with the last owner (park on last). handover=0.
- Undefined: when req=0, grant parks on manager 0. handover pulses if the previous owner was not 0.

Test Plan:
1. Reset then release with req=0000 → grant=0001, handover=0, grant_valid=0.
2. From grant=0001 in ARB, req=1111, HTRANS=IDLE, HREADY=1 for 4 cycles → grant sequence 0010, 0100, 1000, 0001, with handover=1 each cycle.
3. Mgr1 (grant=0010) issues NONSEQ INCR4, then 3 SEQ with one BUSY and one HREADY=0 stall inserted; req=1111 throughout → grant holds 0010 until the edge accepting the 3rd SEQ, then becomes 0100.
4. Mgr2 owner, HMASTLOCK=1 across IDLE cycles, req=1011 → grant holds 0100. Grant moves to 1000 only at the first accepted HMASTLOCK=0 & IDLE beat.
5. Mgr3 owner in UNDEF INCR, req: 1000→0001 mid-burst → grant stays 1000 until req[3]=0 on an accepted beat, then becomes 0001.
6. Assert reset mid-INCR8 (beats_left=5) → grant=0001 asynchronously. After release, a NONSEQ SINGLE with req=0100 → grant=0100. Check parking with req=0000: 0100 stays if ARB_PARK_LAST_EN is defined, else 0001.
